// File: rtl/sd_pkg.sv
// Shared types and constants for the SD-card SPI master.
// ST_INIT exists only when SD_SPI_INIT_CLOCKS_EN is defined.
package sd_pkg;

`ifdef SD_SPI_INIT_CLOCKS_EN
  typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH, ST_INIT} sd_state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH} sd_state_t;
`endif

  localparam int INIT_CLOCKS  = 80;
  localparam int DIV_SLOW_DEF = 62;
  localparam int DIV_FAST_DEF = 1;

endpackage

// File: rtl/sd_spi_divider.sv
// Half-period counter: one-cycle tick every div cycles while en is high, 0-cycle latency.
// Counter restarts whenever en is low, so each phase begins with a full half-period.
module sd_spi_divider (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] div,
  output logic       tick
);

  logic [7:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == div - 8'd1);

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (!en || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sd_spi_master.sv
// SPI mode-0 byte master for SD cards: 16*DIV cycles per byte, start ignored while busy.
// SD_SPI_INIT_CLOCKS_EN adds a post-reset INIT phase of 80 slow clocks with CS high.
module sd_spi_master
  import sd_pkg::*;
#(
  parameter int DIV_SLOW = DIV_SLOW_DEF,
  parameter int DIV_FAST = DIV_FAST_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       fast,
  input  logic       cs_req,
  output logic [7:0] dout,
  output logic       busy,
  output logic       sd_clk,
  output logic       sd_mosi,
  input  logic       sd_miso,
  output logic       sd_cs_n
);

  localparam logic [7:0] DIV_SLOW_B = 8'(DIV_SLOW);
  localparam logic [7:0] DIV_FAST_B = 8'(DIV_FAST);
`ifdef SD_SPI_INIT_CLOCKS_EN
  localparam logic [6:0] INIT_LAST  = 7'(INIT_CLOCKS - 1);
  localparam sd_state_t  RST_STATE  = ST_INIT;
`else
  localparam sd_state_t  RST_STATE  = ST_IDLE;
`endif

  sd_state_t  state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] dout_q, dout_d;
  logic [6:0] cnt_q, cnt_d;
  logic       clk_q, clk_d;
  logic       mosi_q, mosi_d;
  logic       cs_n_q, cs_n_d;
  logic       tick;
  logic       div_en;

  assign div_en = (state_q != ST_IDLE);

  sd_spi_divider u_div (
    .clock (clock),
    .reset (reset),
    .en    (div_en),
    .div   (div_q),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    clk_d   = clk_q;
    mosi_d  = mosi_q;
    cs_n_d  = ~cs_req;
    case (state_q)
      ST_IDLE: begin
        clk_d  = 1'b0;
        mosi_d = 1'b1;
        if (start) begin
          state_d = ST_LOW;
          div_d   = fast ? DIV_FAST_B : DIV_SLOW_B;
          tx_d    = {din[6:0], 1'b0};
          mosi_d  = din[7];
          cnt_d   = '0;
        end
      end
      ST_LOW: begin
        if (tick) begin
          state_d = ST_HIGH;
          clk_d   = 1'b1;
          rx_d    = {rx_q[6:0], sd_miso};
        end
      end
      ST_HIGH: begin
        if (tick) begin
          clk_d = 1'b0;
          if (cnt_q == 7'd7) begin
            state_d = ST_IDLE;
            mosi_d  = 1'b1;
            dout_d  = rx_q;
          end else begin
            state_d = ST_LOW;
            mosi_d  = tx_q[7];
            tx_d    = {tx_q[6:0], 1'b0};
            cnt_d   = cnt_q + 7'd1;
          end
        end
      end
`ifdef SD_SPI_INIT_CLOCKS_EN
      ST_INIT: begin
        // Card wake-up clocks: CS and MOSI held high regardless of requests.
        cs_n_d = 1'b1;
        mosi_d = 1'b1;
        if (tick) begin
          if (!clk_q) begin
            clk_d = 1'b1;
          end else begin
            clk_d = 1'b0;
            if (cnt_q == INIT_LAST) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RST_STATE;
      div_q   <= DIV_SLOW_B;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= 8'hFF;
      cnt_q   <= '0;
      clk_q   <= 1'b0;
      mosi_q  <= 1'b1;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      clk_q   <= clk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
    end
  end

  assign dout    = dout_q;
  assign busy    = (state_q != ST_IDLE);
  assign sd_clk  = clk_q;
  assign sd_mosi = mosi_q;
  assign sd_cs_n = cs_n_q;

  div_range_a: assert property (@(posedge clock)
    (DIV_SLOW >= 1) && (DIV_SLOW <= 255) && (DIV_FAST >= 1) && (DIV_FAST <= 255));

endmodule

// File: tb/tb_sd_spi_master.sv
// Randomized bench for sd_spi_master against a byte-level SPI model (bits, timing, CS).
module tb_sd_spi_master;

  localparam int DSLOW = 62;
  localparam int DFAST = 1;
  localparam int INIT_CYC = 80 * 2 * DSLOW;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] din = 8'h00;
  logic       fast = 1'b0;
  logic       cs_req = 1'b0;
  logic [7:0] dout;
  logic       busy;
  logic       sd_clk;
  logic       sd_mosi;
  logic       sd_miso;
  logic       sd_cs_n;

  sd_spi_master #(.DIV_SLOW(DSLOW), .DIV_FAST(DFAST)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .din     (din),
    .fast    (fast),
    .cs_req  (cs_req),
    .dout    (dout),
    .busy    (busy),
    .sd_clk  (sd_clk),
    .sd_mosi (sd_mosi),
    .sd_miso (sd_miso),
    .sd_cs_n (sd_cs_n)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rise_total = 0;
  int rise_cyc_last = 0;
  int rise_cyc_prev = 0;
  int fall_cnt = 0;
  int miso_base = 0;
  logic [7:0] mosi_sr = 8'h00;
  logic [7:0] miso_byte = 8'hFF;
  logic [7:0] exp_dout = 8'hFF;

`ifdef SD_SPI_INIT_CLOCKS_EN
  localparam logic EXP_RST_BUSY = 1'b1;
`else
  localparam logic EXP_RST_BUSY = 1'b0;
`endif

  always @(posedge clock) cyc++;

  // Card-side observation: MOSI captured on SCK rise, card shifts MISO on SCK fall.
  always @(posedge sd_clk) begin
    rise_total++;
    rise_cyc_prev = rise_cyc_last;
    rise_cyc_last = cyc;
    mosi_sr = {mosi_sr[6:0], sd_mosi};
  end

  always @(negedge sd_clk) fall_cnt++;

  always_comb begin
    int k;
    k = fall_cnt - miso_base;
    sd_miso = 1'b1;
    if (k >= 0 && k < 8) sd_miso = miso_byte[7-k];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called right after a negedge; drives start immediately so back-to-back calls have a 1-cycle gap.
  task automatic do_byte(input logic [7:0] d, input logic [7:0] m, input logic f,
                         input logic cs, input bit disturb);
    int div;
    int nb;
    int r0;
    div = f ? DFAST : DSLOW;
    miso_byte = m;
    miso_base = fall_cnt;
    r0 = rise_total;
    din = d;
    fast = f;
    cs_req = cs;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("ld_busy", busy, 1);
    chk("ld_clk", sd_clk, 0);
    chk("ld_mosi", sd_mosi, d[7]);
    chk("cs_n", sd_cs_n, !cs);
    chk("dout_hold", dout, exp_dout);
    nb = 0;
    while (busy && nb < 20000) begin
      nb++;
      if (disturb && nb == 5) begin
        start = 1'b1;
        fast = ~fast;
        din = ~din;
      end
      if (disturb && nb == 6) start = 1'b0;
      @(negedge clock);
    end
    exp_dout = m;
    chk("busy_cyc", nb, 16 * div);
    chk("dout", dout, m);
    chk("mosi_bits", mosi_sr, d);
    chk("n_rise", rise_total - r0, 8);
    chk("half_per", rise_cyc_last - rise_cyc_prev, 2 * div);
    chk("idle_mosi", sd_mosi, 1);
    chk("idle_clk", sd_clk, 0);
  endtask

  task automatic wait_init();
`ifdef SD_SPI_INIT_CLOCKS_EN
    int nb;
    int bad;
    int r0;
    nb = 0;
    bad = 0;
    r0 = rise_total;
    while (busy && nb < 20000) begin
      nb++;
      if (sd_cs_n !== 1'b1 || sd_mosi !== 1'b1) bad++;
      if (nb == 100) begin
        start = 1'b1;
        cs_req = 1'b1;
      end
      if (nb == 101) start = 1'b0;
      @(negedge clock);
    end
    cs_req = 1'b0;
    chk("init_cyc", nb, INIT_CYC);
    chk("init_rise", rise_total - r0, 80);
    chk("init_cs_mosi", bad, 0);
    repeat (2) @(negedge clock);
    chk("init_no_queue", busy, 0);
`else
    @(negedge clock);
    chk("rst_busy", busy, 0);
`endif
  endtask

  initial begin
    int nb;
    int r0;
    logic [7:0] d;
    logic [7:0] m;
    logic f;
    logic cs;

    repeat (3) @(negedge clock);
    chk("rst_clk", sd_clk, 0);
    chk("rst_mosi", sd_mosi, 1);
    chk("rst_cs_n", sd_cs_n, 1);
    chk("rst_dout", dout, 8'hFF);
    chk("rst_busy_in", busy, EXP_RST_BUSY);
    reset = 1'b0;
    wait_init();

    do_byte(8'hA5, 8'h3C, 1'b1, 1'b1, 1'b0);
    do_byte(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);

    do_byte(8'h5A, 8'hC3, 1'b1, 1'b1, 1'b1);
    r0 = rise_total;
    nb = 0;
    repeat (8) begin
      @(negedge clock);
      if (busy) nb++;
    end
    chk("no_second_busy", nb, 0);
    chk("no_second_rise", rise_total - r0, 0);
    do_byte(8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 3; i++) begin
      do_byte(8'($urandom), 8'($urandom), 1'b1, 1'b1, 1'b0);
    end

    for (int i = 0; i < 14; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      d = 8'($urandom);
      m = 8'($urandom);
      f = ($urandom_range(0, 4) != 0);
      cs = 1'($urandom);
      do_byte(d, m, f, cs, 1'($urandom));
    end

    // Reset in the middle of a slow byte.
    r0 = rise_total;
    miso_byte = 8'h00;
    miso_base = fall_cnt;
    din = 8'h81;
    fast = 1'b0;
    cs_req = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    nb = 0;
    while ((rise_total - r0) < 4 && nb < 3000) begin
      nb++;
      @(negedge clock);
    end
    chk("mid_rise4", rise_total - r0, 4);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("arst_clk", sd_clk, 0);
    chk("arst_cs_n", sd_cs_n, 1);
    chk("arst_busy", busy, EXP_RST_BUSY);
    chk("arst_dout", dout, 8'hFF);
    chk("arst_mosi", sd_mosi, 1);
    @(negedge clock);
    chk("arst_clk_n", sd_clk, 0);
    exp_dout = 8'hFF;
    cs_req = 1'b0;
    reset = 1'b0;
    wait_init();
    do_byte(8'h3C, 8'h96, 1'b1, 1'b1, 1'b0);
    do_byte(8'hC3, 8'h0F, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1);
  end

endmodule
